// File: rtl/outpkt_arbiter_pkg.sv
// Definitions shared by the output-packet arbiter and the output-packet builder:
// packet type codes, field sizes, protocol version and the arbiter FSM encoding.
package outpkt_arbiter_pkg;

    localparam int OUTPKT_TYPE_MSB  = 3;
    localparam int RESULT_LEN       = 4;
    localparam logic [7:0] PKT_COMM_VERSION = 8'h01;

    localparam logic [OUTPKT_TYPE_MSB:0] OUTPKT_TYPE_RESULT      = 4'h1;
    localparam logic [OUTPKT_TYPE_MSB:0] OUTPKT_TYPE_PACKET_DONE = 4'h2;
    localparam logic [OUTPKT_TYPE_MSB:0] OUTPKT_TYPE_ERROR       = 4'h3;
    localparam logic [OUTPKT_TYPE_MSB:0] OUTPKT_TYPE_STATUS      = 4'h4;

    localparam int GRANT_CNT_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } arb_state_e;

endpackage

// File: rtl/outpkt_arb_rr.sv
// Combinational rotate-priority picker: first set request at or above rr_ptr_i, wrapping.
// Works for any N_REQ in 2..16, including non-powers of two.
module outpkt_arb_rr #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    localparam logic [IDX_W:0] N_VAL = (IDX_W+1)'(N_REQ);

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W-1:0]   off;
    logic [IDX_W:0]     sum;

    // rot[k] is the request k places above the pointer
    always_comb begin
        req_dbl = {req_i, req_i} >> rr_ptr_i;
        rot     = req_dbl[N_REQ-1:0];
        off     = '0;
        for (int k = N_REQ-1; k >= 0; k--) begin
            if (rot[k]) begin
                off = IDX_W'(k);
            end
        end
        sum = {1'b0, rr_ptr_i} + {1'b0, off};
        if (sum >= N_VAL) begin
            sum = sum - N_VAL;
        end
    end

    assign vld_o   = |rot;
    assign idx_o   = sum[IDX_W-1:0];
    assign grant_o = vld_o ? (N_REQ'(1) << idx_o) : '0;

endmodule

// File: rtl/outpkt_arbiter.sv
// Round-robin arbiter sharing the output-packet builder; registered descriptor, one packet per 2 cycles.
// Optional per-requester saturating grant counters when OUTPKT_ARB_STATS_EN is defined.
module outpkt_arbiter
    import outpkt_arbiter_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int PKT_TYPE_MSB = OUTPKT_TYPE_MSB,
    parameter int HASH_NUM_MSB = 15,
    parameter int RESULT_BYTES = RESULT_LEN
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_REQ-1:0]                  req_i,
    output logic [N_REQ-1:0]                  ack_o,
    input  logic [N_REQ*(PKT_TYPE_MSB+1)-1:0] req_pkt_type_i,
    input  logic [N_REQ*16-1:0]               req_pkt_id_i,
    input  logic [N_REQ*16-1:0]               req_word_id_i,
    input  logic [N_REQ*32-1:0]               req_gen_id_i,
    input  logic [N_REQ*(HASH_NUM_MSB+1)-1:0] req_hash_num_i,
    input  logic [N_REQ*8*RESULT_BYTES-1:0]   req_result_i,
    output logic                              out_wr_en_o,
    input  logic                              out_full_i,
    output logic [PKT_TYPE_MSB:0]             out_pkt_type_o,
    output logic [15:0]                       out_pkt_id_o,
    output logic [15:0]                       out_word_id_o,
    output logic [31:0]                       out_gen_id_o,
    output logic [HASH_NUM_MSB:0]             out_hash_num_o,
    output logic [8*RESULT_BYTES-1:0]         out_result_o,
`ifdef OUTPKT_ARB_STATS_EN
    output logic [N_REQ*GRANT_CNT_W-1:0]      grant_count_o,
`endif
    output logic                              idle_o
);

    localparam int TW    = PKT_TYPE_MSB + 1;
    localparam int HW    = HASH_NUM_MSB + 1;
    localparam int RW    = 8 * RESULT_BYTES;
    localparam int IDX_W = $clog2(N_REQ);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] ack_q, ack_d;
    logic             wr_en_q, wr_en_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             capture;

    logic [TW-1:0]    type_q, type_sel;
    logic [15:0]      pid_q, pid_sel;
    logic [15:0]      wid_q, wid_sel;
    logic [31:0]      gid_q, gid_sel;
    logic [HW-1:0]    hash_q, hash_sel;
    logic [RW-1:0]    res_q, res_sel;

    logic [N_REQ-1:0] pick_req;
    logic [N_REQ-1:0] pick_grant;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_vld;

    // A requester is still showing its just-acked descriptor while ack is high
    assign pick_req = req_i & ~ack_q;

    outpkt_arb_rr #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i    (pick_req),
        .rr_ptr_i (rr_ptr_q),
        .grant_o  (pick_grant),
        .idx_o    (pick_idx),
        .vld_o    (pick_vld)
    );

    always_comb begin
        type_sel = '0;
        pid_sel  = '0;
        wid_sel  = '0;
        gid_sel  = '0;
        hash_sel = '0;
        res_sel  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_grant[i]) begin
                type_sel = req_pkt_type_i[i*TW +: TW];
                pid_sel  = req_pkt_id_i[i*16 +: 16];
                wid_sel  = req_word_id_i[i*16 +: 16];
                gid_sel  = req_gen_id_i[i*32 +: 32];
                hash_sel = req_hash_num_i[i*HW +: HW];
                res_sel  = req_result_i[i*RW +: RW];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ack_d    = '0;
        wr_en_d  = wr_en_q;
        rr_ptr_d = rr_ptr_q;
        capture  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    capture  = 1'b1;
                    ack_d    = pick_grant;
                    wr_en_d  = 1'b1;
                    rr_ptr_d = (pick_idx == IDX_W'(N_REQ-1)) ? '0 : pick_idx + 1'b1;
                    state_d  = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!out_full_i) begin
                    wr_en_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ack_q    <= '0;
            wr_en_q  <= 1'b0;
            rr_ptr_q <= '0;
            type_q   <= '0;
            pid_q    <= '0;
            wid_q    <= '0;
            gid_q    <= '0;
            hash_q   <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            wr_en_q  <= wr_en_d;
            rr_ptr_q <= rr_ptr_d;
            if (capture) begin
                type_q <= type_sel;
                pid_q  <= pid_sel;
                wid_q  <= wid_sel;
                gid_q  <= gid_sel;
                hash_q <= hash_sel;
                res_q  <= res_sel;
            end
        end
    end

`ifdef OUTPKT_ARB_STATS_EN
    logic [N_REQ*GRANT_CNT_W-1:0] gcnt_q;

    // Counters move on the same edge that raises ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt_q <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (ack_d[i] && (gcnt_q[i*GRANT_CNT_W +: GRANT_CNT_W] != {GRANT_CNT_W{1'b1}})) begin
                    gcnt_q[i*GRANT_CNT_W +: GRANT_CNT_W] <= gcnt_q[i*GRANT_CNT_W +: GRANT_CNT_W] + 1'b1;
                end
            end
        end
    end

    assign grant_count_o = gcnt_q;
`endif

    assign ack_o          = ack_q;
    assign out_wr_en_o    = wr_en_q;
    assign out_pkt_type_o = type_q;
    assign out_pkt_id_o   = pid_q;
    assign out_word_id_o  = wid_q;
    assign out_gen_id_o   = gid_q;
    assign out_hash_num_o = hash_q;
    assign out_result_o   = res_q;
    assign idle_o         = (state_q == ST_IDLE) && (req_i == '0);

endmodule

// File: tb/tb_outpkt_arbiter.sv
// Bench for outpkt_arbiter: queue-based requesters and builder, reference model of the rotation rule.
`timescale 1ns/1ps
module tb_outpkt_arbiter;
    import outpkt_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int TW = OUTPKT_TYPE_MSB + 1;
    localparam int HW = 16;
    localparam int RW = 8 * RESULT_LEN;

    typedef struct packed {
        logic [TW-1:0] t;
        logic [15:0]   pid;
        logic [15:0]   wid;
        logic [31:0]   gid;
        logic [HW-1:0] h;
        logic [RW-1:0] r;
    } desc_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_i = '0;
    logic [N-1:0]    ack_o;
    logic [N*TW-1:0] req_pkt_type_i = '0;
    logic [N*16-1:0] req_pkt_id_i = '0;
    logic [N*16-1:0] req_word_id_i = '0;
    logic [N*32-1:0] req_gen_id_i = '0;
    logic [N*HW-1:0] req_hash_num_i = '0;
    logic [N*RW-1:0] req_result_i = '0;
    logic            out_wr_en_o;
    logic            out_full_i = 1'b0;
    logic [TW-1:0]   out_pkt_type_o;
    logic [15:0]     out_pkt_id_o, out_word_id_o;
    logic [31:0]     out_gen_id_o;
    logic [HW-1:0]   out_hash_num_o;
    logic [RW-1:0]   out_result_o;
    logic            idle_o;
`ifdef OUTPKT_ARB_STATS_EN
    logic [N*16-1:0] grant_count_o;
    int gcnt[N];
`endif

    outpkt_arbiter #(.N_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_i(req_i), .ack_o(ack_o),
        .req_pkt_type_i(req_pkt_type_i), .req_pkt_id_i(req_pkt_id_i),
        .req_word_id_i(req_word_id_i), .req_gen_id_i(req_gen_id_i),
        .req_hash_num_i(req_hash_num_i), .req_result_i(req_result_i),
        .out_wr_en_o(out_wr_en_o), .out_full_i(out_full_i),
        .out_pkt_type_o(out_pkt_type_o), .out_pkt_id_o(out_pkt_id_o),
        .out_word_id_o(out_word_id_o), .out_gen_id_o(out_gen_id_o),
        .out_hash_num_o(out_hash_num_o), .out_result_o(out_result_o),
`ifdef OUTPKT_ARB_STATS_EN
        .grant_count_o(grant_count_o),
`endif
        .idle_o(idle_o)
    );

    desc_t out_desc;
    assign out_desc = {out_pkt_type_o, out_pkt_id_o, out_word_id_o, out_gen_id_o, out_hash_num_o, out_result_o};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference state: pending descriptors per requester, builder busy flag, rotation pointer
    desc_t      pq[N][$];
    desc_t      acc_log[$];
    int         grant_log[$];
    int         grant_cyc[$];
    desc_t      m_desc;
    bit         m_busy;
    int         m_ptr;
    logic [N-1:0] m_ack;
    int         wait_cnt[N];
    int         cyc, seq, n_pushed, n_acc;

    task automatic push(input int i, input logic [TW-1:0] t, input logic [15:0] pid);
        desc_t d;
        d.t   = t;
        d.pid = pid;
        d.wid = 16'($urandom);
        d.gid = {8'(i), 24'(seq)};
        d.h   = 16'($urandom);
        d.r   = 32'($urandom);
        seq++;
        n_pushed++;
        pq[i].push_back(d);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (pq[i].size() > 0) begin
                req_i[i] = 1'b1;
                req_pkt_type_i[i*TW +: TW] = pq[i][0].t;
                req_pkt_id_i[i*16 +: 16]   = pq[i][0].pid;
                req_word_id_i[i*16 +: 16]  = pq[i][0].wid;
                req_gen_id_i[i*32 +: 32]   = pq[i][0].gid;
                req_hash_num_i[i*HW +: HW] = pq[i][0].h;
                req_result_i[i*RW +: RW]   = pq[i][0].r;
            end else begin
                req_i[i] = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_ptr  = 0;
        m_ack  = '0;
        m_desc = '0;
        for (int i = 0; i < N; i++) begin
            pq[i].delete();
            wait_cnt[i] = 0;
`ifdef OUTPKT_ARB_STATS_EN
            gcnt[i] = 0;
`endif
        end
    endtask

    task automatic tick();
        logic [N-1:0] rq, ea, sh;
        int  g;
        bit  found;
        @(posedge clk);
        #1;
        cyc++;
        rq = req_i & ~m_ack;
        ea = '0;
        g = 0;
        found = 1'b0;
        if (m_busy) begin
            if (!out_full_i) begin
                m_busy = 1'b0;
                acc_log.push_back(out_desc);
                n_acc++;
                chk("acc_desc", out_desc, m_desc);
            end
        end else if (rq != '0) begin
            for (int k = 0; k < N; k++) begin
                sh = rq >> ((m_ptr + k) % N);
                if (!found && sh[0]) begin
                    g = (m_ptr + k) % N;
                    found = 1'b1;
                end
            end
            ea = N'(1) << g;
            m_busy = 1'b1;
            m_desc = pq[g][0];
            m_ptr  = (g + 1) % N;
            grant_log.push_back(g);
            grant_cyc.push_back(cyc);
            chk("fair_wait", wait_cnt[g] <= N-1, 1'b1);
            wait_cnt[g] = 0;
            for (int j = 0; j < N; j++) begin
                sh = req_i >> j;
                if (j != g && sh[0]) wait_cnt[j]++;
            end
`ifdef OUTPKT_ARB_STATS_EN
            if (gcnt[g] < 65535) gcnt[g]++;
`endif
        end
        m_ack = ea;
        chk("ack", ack_o, ea);
        chk("wr_en", out_wr_en_o, m_busy);
        if (m_busy) chk("desc", out_desc, m_desc);
        chk("idle", idle_o, !m_busy && (req_i == '0));
`ifdef OUTPKT_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("grant_count", grant_count_o[i*16 +: 16], 16'(gcnt[i]));
`endif
        if (found) pq[g].delete(0);
        drive();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        out_full_i = 1'b0;
        model_reset();
        drive();
        #1;
        chk("rst_ack", ack_o, '0);
        chk("rst_wr_en", out_wr_en_o, 1'b0);
        chk("rst_idle", idle_o, 1'b1);
        chk("rst_desc", out_desc, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_grants(input int n, input string tag);
        for (int c = 0; c < 200 && grant_log.size() < n; c++) tick();
        if (grant_log.size() < n) chk({tag, "_timeout"}, 1'b0, 1'b1);
    endtask

    task automatic drain(input string tag);
        bit busy_left;
        out_full_i = 1'b0;
        busy_left = 1'b1;
        for (int c = 0; c < 500 && busy_left; c++) begin
            tick();
            busy_left = m_busy;
            for (int i = 0; i < N; i++) if (pq[i].size() > 0) busy_left = 1'b1;
        end
        if (busy_left) chk({tag, "_drain_timeout"}, 1'b0, 1'b1);
    endtask

    initial begin
        int n0, a0, p0, c0;
        int rot_exp[6];
        rot_exp = '{0, 1, 2, 3, 0, 1};
        cyc = 0; seq = 0; n_pushed = 0; n_acc = 0;

        // Single request from requester 2 after reset, then pointer must sit at 3
        do_reset();
        push(2, OUTPKT_TYPE_RESULT, 16'h0011);
        drive();
        c0 = cyc;
        n0 = grant_log.size();
        wait_grants(n0 + 1, "t1");
        if (grant_log.size() > n0) begin
            chk("t1_grant", grant_log[n0], 2);
            chk("t1_latency", grant_cyc[n0] - c0, 1);
        end
        drain("t1");
        push(0, OUTPKT_TYPE_STATUS, 16'h0001);
        push(3, OUTPKT_TYPE_STATUS, 16'h0003);
        drive();
        wait_grants(n0 + 2, "t1b");
        if (grant_log.size() > n0 + 1) chk("t1_rr_ptr", grant_log[n0+1], 3);
        drain("t1b");

        // Builder full for 20 cycles: output held, no other acks
        out_full_i = 1'b1;
        push(1, OUTPKT_TYPE_RESULT, 16'h0101);
        drive();
        n0 = grant_log.size();
        wait_grants(n0 + 1, "t3");
        a0 = n_acc;
        push(0, OUTPKT_TYPE_RESULT, 16'h0200);
        push(2, OUTPKT_TYPE_RESULT, 16'h0202);
        drive();
        repeat (20) tick();
        chk("t3_no_accept", n_acc, a0);
        chk("t3_no_new_grant", grant_log.size(), n0 + 1);
        out_full_i = 1'b0;
        tick();
        chk("t3_accept", n_acc, a0 + 1);
        drain("t3");

        // RESULT then PACKET_DONE from requester 3 reach the builder in order
        a0 = acc_log.size();
        push(3, OUTPKT_TYPE_RESULT, 16'd5);
        push(3, OUTPKT_TYPE_PACKET_DONE, 16'd5);
        drive();
        drain("t4");
        chk("t4_count", acc_log.size(), a0 + 2);
        if (acc_log.size() >= a0 + 2) begin
            chk("t4_first_type", acc_log[a0].t, OUTPKT_TYPE_RESULT);
            chk("t4_second_type", acc_log[a0+1].t, OUTPKT_TYPE_PACKET_DONE);
            chk("t4_pid", {acc_log[a0].pid, acc_log[a0+1].pid}, {16'd5, 16'd5});
        end

        // Asynchronous reset while a captured packet is waiting
        out_full_i = 1'b1;
        push(1, OUTPKT_TYPE_RESULT, 16'h0303);
        drive();
        n0 = grant_log.size();
        wait_grants(n0 + 1, "t5");
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        drive();
        #1;
        chk("t5_wr_en", out_wr_en_o, 1'b0);
        chk("t5_ack", ack_o, '0);
        chk("t5_idle", idle_o, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        out_full_i = 1'b0;
        push(1, OUTPKT_TYPE_RESULT, 16'h0401);
        push(3, OUTPKT_TYPE_RESULT, 16'h0403);
        drive();
        n0 = grant_log.size();
        wait_grants(n0 + 1, "t5b");
        if (grant_log.size() > n0) chk("t5_ptr_restart", grant_log[n0], 1);
        drain("t5");

        // All requesters busy: strict rotation, one grant every two cycles
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < N; i++) push(i, 4'($urandom_range(0, 15)), 16'($urandom));
        drive();
        n0 = grant_log.size();
        wait_grants(n0 + 6, "t2");
        if (grant_log.size() >= n0 + 6) begin
            for (int k = 0; k < 6; k++) chk("t2_order", grant_log[n0+k], rot_exp[k]);
            for (int k = 1; k < 6; k++) chk("t2_spacing", grant_cyc[n0+k] - grant_cyc[n0+k-1], 2);
        end
        drain("t2");

        // Random traffic with random builder backpressure
        p0 = n_pushed;
        a0 = n_acc;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (pq[i].size() < 4 && $urandom_range(0, 3) == 0)
                    push(i, 4'($urandom_range(0, 15)), 16'($urandom));
            out_full_i = ($urandom_range(0, 2) == 0);
            drive();
            tick();
        end
        drain("rand");
        chk("rand_all_delivered", n_acc - a0, n_pushed - p0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
